// File: rtl/qcl_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : qcl_edge_event_arbiter
//  Description : Per-channel edge capture into pending flags, serialised
//                round-robin onto a single valid/ready event port.
//  Revision    : 1.0 - initial release
// ============================================================================
module qcl_edge_event_arbiter #(
   parameter int num_req_p            = 4,
   parameter bit falling_not_rising_p = 1'b0,
   parameter bit reset_val_p          = 1'b0,
   localparam int id_width_lp         = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [num_req_p-1:0]   sig_i,
   input  logic [num_req_p-1:0]   en_i,
   output logic                   v_o,
   output logic [id_width_lp-1:0] id_o,
   input  logic                   ready_i,
   output logic [num_req_p-1:0]   pending_o,
   output logic [num_req_p-1:0]   ovf_o,
   input  logic [num_req_p-1:0]   ovf_clr_i
);

   localparam logic [id_width_lp-1:0] c_last_rst = id_width_lp'(num_req_p - 1);
   localparam logic [id_width_lp:0]   c_num_req  = (id_width_lp + 1)'(num_req_p);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_OFFER = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [num_req_p-1:0]   r_sig;
   logic [num_req_p-1:0]   r_pend;
   logic [num_req_p-1:0]   r_ovf;
   logic [id_width_lp-1:0] r_id;
   logic [id_width_lp-1:0] r_last;

   logic [num_req_p-1:0]   w_det;
   logic [num_req_p-1:0]   w_cap;
   logic [num_req_p-1:0]   w_clr;
   logic [num_req_p-1:0]   w_pend_nxt;
   logic [num_req_p-1:0]   w_ovf_nxt;
   logic [id_width_lp:0]   w_scan;
   logic [id_width_lp-1:0] w_winner;
   logic                   w_found;
   logic                   w_load;

   generate
      if (falling_not_rising_p) begin : g_fall
         assign w_det = ~sig_i & r_sig;
      end else begin : g_rise
         assign w_det = sig_i & ~r_sig;
      end
   endgenerate

   assign w_cap = w_det & en_i;

   // Round-robin scan starting just after the last winner, wrapping mod num_req_p.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_scan   = '0;
      for (int k = 1; k <= num_req_p; k++) begin
         w_scan = {1'b0, r_last} + (id_width_lp + 1)'(k);
         if (w_scan >= c_num_req) begin
            w_scan = w_scan - c_num_req;
         end
         if (!w_found && r_pend[w_scan]) begin
            w_found  = 1'b1;
            w_winner = w_scan[id_width_lp-1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|r_pend) begin
               w_load      = 1'b1;
               w_state_nxt = S_OFFER;
            end
         end
         S_OFFER: begin
            if (ready_i) begin
               if (|r_pend) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A capture coinciding with the load re-arms pending without flagging overflow.
   always_comb begin
      w_clr = '0;
      for (int i = 0; i < num_req_p; i++) begin
         w_clr[i] = w_load && (w_winner == id_width_lp'(i));
      end
      w_pend_nxt = (r_pend & ~w_clr) | w_cap;
      w_ovf_nxt  = (w_cap & r_pend & ~w_clr) | (r_ovf & ~ovf_clr_i);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_sig  <= {num_req_p{reset_val_p}};
         r_pend <= '0;
         r_ovf  <= '0;
         r_id   <= '0;
         r_last <= c_last_rst;
      end else begin
         r_sig  <= sig_i;
         r_pend <= w_pend_nxt;
         r_ovf  <= w_ovf_nxt;
         if (w_load) begin
            r_id   <= w_winner;
            r_last <= w_winner;
         end
      end
   end

   assign v_o       = (r_state == S_OFFER);
   assign id_o      = r_id;
   assign pending_o = r_pend;
   assign ovf_o     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_qcl_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qcl_edge_event_arbiter
//  Description : Directed self-checking bench for qcl_edge_event_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qcl_edge_event_arbiter;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic [3:0] sig_i;
   logic [3:0] en_i;
   logic       v_o;
   logic [1:0] id_o;
   logic       ready_i;
   logic [3:0] pending_o;
   logic [3:0] ovf_o;
   logic [3:0] ovf_clr_i;

   int checks = 0;
   int errors = 0;

   qcl_edge_event_arbiter #(
      .num_req_p(4),
      .falling_not_rising_p(1'b0),
      .reset_val_p(1'b0)
   ) dut (
      .clk_i(clk_i),
      .reset_n_i(reset_n_i),
      .sig_i(sig_i),
      .en_i(en_i),
      .v_o(v_o),
      .id_o(id_o),
      .ready_i(ready_i),
      .pending_o(pending_o),
      .ovf_o(ovf_o),
      .ovf_clr_i(ovf_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      sig_i     = 4'b0000;
      en_i      = 4'b1111;
      ready_i   = 1'b0;
      ovf_clr_i = 4'b0000;
      step();
      step();
      reset_n_i = 1'b1;
      step();
   endtask

   initial begin
      // 1: single rising edge latency
      do_reset();
      chk("rst_v", v_o, 1'b0);
      chk("rst_id", id_o, 2'd0);
      chk("rst_pend", pending_o, 4'b0000);
      chk("rst_ovf", ovf_o, 4'b0000);
      ready_i = 1'b1;
      sig_i   = 4'b0100;
      step();
      chk("t1_pend", pending_o, 4'b0100);
      chk("t1_v0", v_o, 1'b0);
      step();
      chk("t1_v", v_o, 1'b1);
      chk("t1_id", id_o, 2'd2);
      chk("t1_pend_clr", pending_o, 4'b0000);
      step();
      chk("t1_v_done", v_o, 1'b0);
      chk("t1_pend_done", pending_o, 4'b0000);

      // 2: four simultaneous edges, twice, back-to-back service
      do_reset();
      ready_i = 1'b1;
      for (int r = 0; r < 2; r++) begin
         sig_i = 4'b1111;
         step();
         chk("t2_pend", pending_o, 4'b1111);
         sig_i = 4'b0000;
         for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_v_r%0d_k%0d", r, k), v_o, 1'b1);
            chk($sformatf("t2_id_r%0d_k%0d", r, k), id_o, k);
         end
         step();
         chk($sformatf("t2_idle_r%0d", r), v_o, 1'b0);
      end

      // 3: repeated edges while offer stalls; overflow and clear
      do_reset();
      sig_i = 4'b0010;
      step();
      sig_i = 4'b0000;
      step();
      chk("t3_v", v_o, 1'b1);
      chk("t3_id", id_o, 2'd1);
      chk("t3_pend0", pending_o, 4'b0000);
      sig_i = 4'b0010;
      step();
      chk("t3_pend1", pending_o, 4'b0010);
      chk("t3_ovf_none", ovf_o, 4'b0000);
      sig_i = 4'b0000;
      step();
      sig_i = 4'b0010;
      step();
      chk("t3_ovf_set", ovf_o, 4'b0010);
      chk("t3_v_held", v_o, 1'b1);
      chk("t3_id_held", id_o, 2'd1);
      sig_i     = 4'b0000;
      ovf_clr_i = 4'b0010;
      step();
      ovf_clr_i = 4'b0000;
      chk("t3_ovf_clr", ovf_o, 4'b0000);
      ready_i = 1'b1;
      step();
      chk("t3_v2", v_o, 1'b1);
      chk("t3_id2", id_o, 2'd1);
      chk("t3_pend2", pending_o, 4'b0000);
      step();
      chk("t3_idle", v_o, 1'b0);

      // 4: capture enable masks channel 0
      do_reset();
      en_i    = 4'b1110;
      ready_i = 1'b1;
      sig_i   = 4'b1001;
      step();
      chk("t4_pend", pending_o, 4'b1000);
      step();
      chk("t4_v", v_o, 1'b1);
      chk("t4_id", id_o, 2'd3);
      step();
      chk("t4_idle", v_o, 1'b0);
      chk("t4_pend_done", pending_o, 4'b0000);
      en_i = 4'b1111;

      // 5: overflow set beats same-cycle clear
      do_reset();
      sig_i = 4'b0100;
      step();
      sig_i = 4'b0000;
      step();
      sig_i = 4'b0100;
      step();
      sig_i = 4'b0000;
      step();
      sig_i     = 4'b0100;
      ovf_clr_i = 4'b0100;
      step();
      chk("t5_ovf_wins", ovf_o, 4'b0100);
      sig_i = 4'b0000;
      step();
      ovf_clr_i = 4'b0000;
      chk("t5_ovf_clr", ovf_o, 4'b0000);

      // 6: async reset mid-offer, then RR restarts from channel 0
      do_reset();
      sig_i = 4'b0100;
      step();
      sig_i = 4'b0000;
      step();
      sig_i = 4'b1010;
      step();
      chk("t6_v_pre", v_o, 1'b1);
      chk("t6_pend_pre", pending_o, 4'b1010);
      reset_n_i = 1'b0;
      #1;
      chk("t6_v_rst", v_o, 1'b0);
      chk("t6_pend_rst", pending_o, 4'b0000);
      chk("t6_ovf_rst", ovf_o, 4'b0000);
      step();
      reset_n_i = 1'b1;
      ready_i   = 1'b1;
      step();
      chk("t6_pend_post", pending_o, 4'b1010);
      step();
      chk("t6_v1", v_o, 1'b1);
      chk("t6_id1", id_o, 2'd1);
      step();
      chk("t6_id3", id_o, 2'd3);
      step();
      chk("t6_idle", v_o, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
